// File: rtl/eqopp_pkg.sv
// Shared types and default parameters for the equal-opportunity arbiter.
// The optional grant statistics are enabled with the EQOPP_STATS_EN macro.
package eqopp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  typedef enum logic {
    WIN_A = 1'b0,
    WIN_B = 1'b1
  } winner_t;

  localparam int unsigned MAX_HOLD_DEF     = 4;
  localparam int unsigned WAIT_W_DEF       = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned CNT_W_DEF        = 8;
  localparam int unsigned IMB_LIMIT_DEF    = 4;
  localparam int unsigned HOLD_W           = 4;

endpackage

// File: rtl/eqopp_wait_ctr.sv
// Saturating per-requester wait counter with its starvation compare.
module eqopp_wait_ctr
  import eqopp_pkg::*;
#(
  parameter int unsigned WAIT_W       = WAIT_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic grant_i,
  output logic starve_o
);

  logic [WAIT_W-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (!req_i || grant_i) begin
      wait_d = '0;
    end else if (wait_q != '1) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign starve_o = (wait_q >= WAIT_W'(STARVE_LIMIT));

endmodule

// File: rtl/eqopp_arbiter.sv
// Two-requester round-robin arbiter with hold limit, starvation flags and
// optional grant statistics (EQOPP_STATS_EN).
//   state | meaning
//   IDLE  | no grant outstanding
//   GNT_A | requester A owns the grant
//   GNT_B | requester B owns the grant
module eqopp_arbiter
  import eqopp_pkg::*;
#(
  parameter int unsigned MAX_HOLD     = MAX_HOLD_DEF,
  parameter int unsigned WAIT_W       = WAIT_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned IMB_LIMIT    = IMB_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a_i,
  input  logic             req_b_i,
  output logic             grant_a_o,
  output logic             grant_b_o,
  output logic             starve_a_o,
  output logic             starve_b_o,
  output logic [CNT_W-1:0] gcnt_a_o,
  output logic [CNT_W-1:0] gcnt_b_o,
  output logic             imbalance_o
);

  state_t            state_q, state_d;
  winner_t           last_win_q, last_win_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              grant_a_q, grant_b_q;
  logic              start_a, start_b;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    last_win_d = last_win_q;
    case (state_q)
      IDLE: begin
        if (req_a_i && (!req_b_i || last_win_q == WIN_B)) state_d = GNT_A;
        else if (req_b_i)                                 state_d = GNT_B;
      end
      GNT_A: begin
        if (!req_a_i)                                         state_d = req_b_i ? GNT_B : IDLE;
        else if (req_b_i && hold_q == HOLD_W'(MAX_HOLD))      state_d = GNT_B;
      end
      GNT_B: begin
        if (!req_b_i)                                         state_d = req_a_i ? GNT_A : IDLE;
        else if (req_a_i && hold_q == HOLD_W'(MAX_HOLD))      state_d = GNT_A;
      end
      default: state_d = IDLE;
    endcase

    start_a = (state_d == GNT_A) && (state_q != GNT_A);
    start_b = (state_d == GNT_B) && (state_q != GNT_B);
    if (start_a)      last_win_d = WIN_A;
    else if (start_b) last_win_d = WIN_B;

    // hold_cnt is 1 on the first grant cycle and saturates at the limit
    if (start_a || start_b) begin
      hold_d = HOLD_W'(1);
    end else if (state_d != IDLE && hold_q != HOLD_W'(MAX_HOLD)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_win_q <= WIN_B;
      hold_q     <= '0;
      grant_a_q  <= 1'b0;
      grant_b_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      hold_q     <= hold_d;
      grant_a_q  <= (state_d == GNT_A);
      grant_b_q  <= (state_d == GNT_B);
    end
  end

  assign grant_a_o = grant_a_q;
  assign grant_b_o = grant_b_q;

  eqopp_wait_ctr #(.WAIT_W(WAIT_W), .STARVE_LIMIT(STARVE_LIMIT)) u_wait_a (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_a_i),
    .grant_i  (grant_a_q),
    .starve_o (starve_a_o)
  );

  eqopp_wait_ctr #(.WAIT_W(WAIT_W), .STARVE_LIMIT(STARVE_LIMIT)) u_wait_b (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_b_i),
    .grant_i  (grant_b_q),
    .starve_o (starve_b_o)
  );

`ifdef EQOPP_STATS_EN
  logic [CNT_W-1:0]        gcnt_a_q, gcnt_b_q;
  logic signed [CNT_W:0]   diff;
  logic [CNT_W:0]          adiff;

  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt_a_q <= '0;
      gcnt_b_q <= '0;
    end else begin
      if (start_a && gcnt_a_q != '1) gcnt_a_q <= gcnt_a_q + CNT_W'(1);
      if (start_b && gcnt_b_q != '1) gcnt_b_q <= gcnt_b_q + CNT_W'(1);
    end
  end

  // one extra bit keeps the difference exact in both directions
  assign diff        = $signed({1'b0, gcnt_a_q}) - $signed({1'b0, gcnt_b_q});
  assign adiff       = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign gcnt_a_o    = gcnt_a_q;
  assign gcnt_b_o    = gcnt_b_q;
  assign imbalance_o = (adiff > (CNT_W+1)'(IMB_LIMIT));
`else
  assign gcnt_a_o    = '0;
  assign gcnt_b_o    = '0;
  assign imbalance_o = 1'b0;
`endif

endmodule

// File: tb/tb_eqopp_arbiter.sv
// Self-checking bench for eqopp_arbiter: vector table fed through a scoreboard queue.
module tb_eqopp_arbiter;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u_dut uses default parameters, u_long a longer hold to provoke starvation
  logic rst0 = 1'b1, ra0 = 1'b0, rb0 = 1'b0;
  logic ga0, gb0, sa0, sb0, imb0;
  logic [CNT_W-1:0] gca0, gcb0;
  logic rst1 = 1'b1, ra1 = 1'b0, rb1 = 1'b0;
  logic ga1, gb1, sa1, sb1, imb1;
  logic [CNT_W-1:0] gca1, gcb1;

  eqopp_arbiter u_dut (
    .clk(clk), .reset(rst0), .req_a_i(ra0), .req_b_i(rb0),
    .grant_a_o(ga0), .grant_b_o(gb0), .starve_a_o(sa0), .starve_b_o(sb0),
    .gcnt_a_o(gca0), .gcnt_b_o(gcb0), .imbalance_o(imb0)
  );

  eqopp_arbiter #(.MAX_HOLD(12)) u_long (
    .clk(clk), .reset(rst1), .req_a_i(ra1), .req_b_i(rb1),
    .grant_a_o(ga1), .grant_b_o(gb1), .starve_a_o(sa1), .starve_b_o(sb1),
    .gcnt_a_o(gca1), .gcnt_b_o(gcb1), .imbalance_o(imb1)
  );

  typedef struct {
    int   sel;
    logic rst, ra, rb;
    logic ga, gb, sa, sb;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  task automatic add(input int sel, input logic rst, input logic ra, input logic rb,
                     input logic ga, input logic gb, input logic sa, input logic sb);
    vec_t v;
    v.sel = sel; v.rst = rst; v.ra = ra; v.rb = rb;
    v.ga = ga; v.gb = gb; v.sa = sa; v.sb = sb;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    vec_t e;
    logic [3:0] act, exp;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty step=%0d", step_no);
      return;
    end
    e = sb_q.pop_front();
    act = (e.sel == 0) ? {ga0, gb0, sa0, sb0} : {ga1, gb1, sa1, sb1};
    exp = {e.ga, e.gb, e.sa, e.sb};
    if (act !== exp) begin
      bad++;
      $display("FAIL vec step=%0d dut=%0d {ga,gb,sa,sb} got=%b want=%b", step_no, e.sel, act, exp);
    end
    total++;
    if ((ga0 && gb0) || (ga1 && gb1)) begin
      bad++;
      $display("FAIL mutex step=%0d got ga0/gb0=%b%b ga1/gb1=%b%b want no both-high", step_no, ga0, gb0, ga1, gb1);
    end
  endtask

  task automatic apply(input vec_t v);
    if (v.sel == 0) begin
      rst0 = v.rst; ra0 = v.ra; rb0 = v.rb;
      rst1 = 1'b1;  ra1 = 1'b0; rb1 = 1'b0;
    end else begin
      rst1 = v.rst; ra1 = v.ra; rb1 = v.rb;
      rst0 = 1'b1;  ra0 = 1'b0; rb0 = 1'b0;
    end
    sb_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    check_out();
    step_no++;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  initial begin
    @(negedge clk);

    // solo A, then idle
    add(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) add(0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // both requesting from reset: A x4, B x4, A ...
    add(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) add(0, 0, 1, 1, 1, 0, 0, 0);
    repeat (4) add(0, 0, 1, 1, 0, 1, 0, 0);
    repeat (2) add(0, 0, 1, 1, 1, 0, 0, 0);
    // A drops mid-hold: B takes over with no gap, then keeps it alone
    repeat (3) add(0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // reset in GNT_B with both requesting; A wins the tie afterwards
    add(0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0);
    repeat (2) add(0, 0, 1, 1, 1, 0, 0, 0);

    // long hold: starve_b at the 8th waiting cycle, clears after grant
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 0);
    for (int n = 2; n <= 12; n++) add(1, 0, 1, 1, 1, 0, 0, logic'(n >= 9));
    add(1, 0, 1, 1, 0, 1, 0, 1);
    add(1, 0, 1, 1, 0, 1, 0, 0);
    // long hold: starve_b clears after B drops its request
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 0);
    for (int n = 2; n <= 10; n++) add(1, 0, 1, 1, 1, 0, 0, logic'(n >= 9));
    add(1, 0, 1, 0, 1, 0, 0, 0);

    // six separated solo-A grants for the statistics
    add(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (6) begin
      add(0, 0, 1, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

`ifdef EQOPP_STATS_EN
    cmp("gcnt_a", int'(gca0), 6);
    cmp("gcnt_b", int'(gcb0), 0);
    cmp("imbalance", int'(imb0), 1);
`else
    cmp("gcnt_a", int'(gca0), 0);
    cmp("gcnt_b", int'(gcb0), 0);
    cmp("imbalance", int'(imb0), 0);
`endif

    // reset clears the statistics as well
    rst0 = 1'b1; ra0 = 1'b0; rb0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmp("gcnt_a_after_reset", int'(gca0), 0);
    cmp("imbalance_after_reset", int'(imb0), 0);
    cmp("scoreboard_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
